// File: rtl/dvdd_seq_pkg.sv
// Shared definitions for the DVDD supply sequencer: state encoding and default timing constants.
package dvdd_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_ISO_REL  = 3'd2,
        ST_IO_ON    = 3'd3,
        ST_ON       = 3'd4
    } seq_state_e;

    localparam int unsigned DEB_CYCLES_DEF = 64;
    localparam int unsigned ISO_DLY_DEF    = 16;

endpackage : dvdd_seq_pkg

// File: rtl/dvdd_seq_sync.sv
// Single-bit multi-flop synchronizer for asynchronous comparator flags; resets to 0.
module dvdd_seq_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : dvdd_seq_sync

// File: rtl/dvdd_supply_sequencer.sv
// Power-up / brown-out sequencer: debounce supply-good, release isolation, then enable pads.
// Optional brown-out event counter enabled with `define DVDD_SEQ_BROWNOUT_CNT_EN.
module dvdd_supply_sequencer
    import dvdd_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int unsigned ISO_DLY     = ISO_DLY_DEF,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       DVDD_OK,
    input  logic       VDD_OK,
    output logic       ISO_N,
    output logic       IO_EN,
    output logic       PWR_GOOD,
    output logic [2:0] STATE
`ifdef DVDD_SEQ_BROWNOUT_CNT_EN
    ,
    input  logic       BO_CLR,
    output logic [7:0] BO_COUNT
`endif
);

    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;
    // Terminal counts clamp to the counter range so a misconfigured build still terminates.
    localparam int unsigned DEB_LAST = (DEB_CYCLES - 1 > CNT_MAX) ? CNT_MAX : DEB_CYCLES - 1;
    localparam int unsigned ISO_LAST = (ISO_DLY - 1 > CNT_MAX) ? CNT_MAX : ISO_DLY - 1;
    localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEB_LAST);
    localparam logic [CNT_W-1:0] ISO_TERM = CNT_W'(ISO_LAST);

    logic dvdd_ok_s;
    logic vdd_ok_s;
    logic ok_s;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             iso_n_q, iso_n_d;
    logic             io_en_q, io_en_d;
    logic             pwr_good_q, pwr_good_d;

    dvdd_seq_sync #(.STAGES(SYNC_STAGES)) u_sync_dvdd (
        .clk   (CLK),
        .rst_n (RSTN),
        .d     (DVDD_OK),
        .q     (dvdd_ok_s)
    );

    dvdd_seq_sync #(.STAGES(SYNC_STAGES)) u_sync_vdd (
        .clk   (CLK),
        .rst_n (RSTN),
        .d     (VDD_OK),
        .q     (vdd_ok_s)
    );

    assign ok_s = dvdd_ok_s & vdd_ok_s;

    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    // Supply loss is tested first in every active state so it beats any terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (ok_s) begin
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!ok_s) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_TERM) begin
                    state_d = ST_ISO_REL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ISO_REL: begin
                if (!ok_s) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == ISO_TERM) begin
                    state_d = ST_IO_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_IO_ON: begin
                cnt_d   = '0;
                state_d = ok_s ? ST_ON : ST_OFF;
            end
            ST_ON: begin
                cnt_d = '0;
                if (!ok_s) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        iso_n_d    = (state_d == ST_ISO_REL) || (state_d == ST_IO_ON) || (state_d == ST_ON);
        io_en_d    = (state_d == ST_IO_ON) || (state_d == ST_ON);
        pwr_good_d = (state_d == ST_ON);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_OFF;
            cnt_q      <= '0;
            iso_n_q    <= 1'b0;
            io_en_q    <= 1'b0;
            pwr_good_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            iso_n_q    <= iso_n_d;
            io_en_q    <= io_en_d;
            pwr_good_q <= pwr_good_d;
        end
    end

    assign ISO_N    = iso_n_q;
    assign IO_EN    = io_en_q;
    assign PWR_GOOD = pwr_good_q;
    assign STATE    = state_q;

`ifdef DVDD_SEQ_BROWNOUT_CNT_EN
    logic       bo_event;
    logic [7:0] bo_cnt_q, bo_cnt_d;

    assign bo_event = !ok_s &&
                      ((state_q == ST_ISO_REL) || (state_q == ST_IO_ON) || (state_q == ST_ON));

    always_comb begin
        bo_cnt_d = bo_cnt_q;
        if (BO_CLR) begin
            bo_cnt_d = '0;
        end else if (bo_event && (bo_cnt_q != '1)) begin
            bo_cnt_d = bo_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            bo_cnt_q <= '0;
        end else begin
            bo_cnt_q <= bo_cnt_d;
        end
    end

    assign BO_COUNT = bo_cnt_q;
`endif

endmodule : dvdd_supply_sequencer

// File: tb/tb_dvdd_supply_sequencer.sv
// Directed self-checking bench for dvdd_supply_sequencer (default parameters).
module tb_dvdd_supply_sequencer;

    logic       CLK;
    logic       RSTN;
    logic       DVDD_OK;
    logic       VDD_OK;
    logic       ISO_N;
    logic       IO_EN;
    logic       PWR_GOOD;
    logic [2:0] STATE;
`ifdef DVDD_SEQ_BROWNOUT_CNT_EN
    logic       BO_CLR;
    logic [7:0] BO_COUNT;
`endif

    int n_cmp;
    int n_bad;

    dvdd_supply_sequencer dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .DVDD_OK  (DVDD_OK),
        .VDD_OK   (VDD_OK),
        .ISO_N    (ISO_N),
        .IO_EN    (IO_EN),
        .PWR_GOOD (PWR_GOOD),
        .STATE    (STATE)
`ifdef DVDD_SEQ_BROWNOUT_CNT_EN
        ,
        .BO_CLR   (BO_CLR),
        .BO_COUNT (BO_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic iso,
                              input logic ioe, input logic pg);
        check({tag, "_state"}, {5'd0, STATE}, {5'd0, st});
        check({tag, "_iso_n"}, {7'd0, ISO_N}, {7'd0, iso});
        check({tag, "_io_en"}, {7'd0, IO_EN}, {7'd0, ioe});
        check({tag, "_pwr_good"}, {7'd0, PWR_GOOD}, {7'd0, pg});
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        for (int i = 0; i < budget && STATE !== st; i++) begin
            ticks(1);
        end
        check(tag, {5'd0, STATE}, {5'd0, st});
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        RSTN    = 1'b0;
        DVDD_OK = 1'b0;
        VDD_OK  = 1'b0;
`ifdef DVDD_SEQ_BROWNOUT_CNT_EN
        BO_CLR  = 1'b0;
`endif
        ticks(2);
        check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        RSTN = 1'b1;
        ticks(1);

        // Power-up: inputs applied now, sync 2 + debounce 65 to ISO_REL
        DVDD_OK = 1'b1;
        VDD_OK  = 1'b1;
        ticks(2);
        check_outs("pu_sync", 3'd0, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check_outs("pu_deb", 3'd1, 1'b0, 1'b0, 1'b0);
        ticks(63);
        check_outs("pu_deb_last", 3'd1, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check_outs("pu_iso_rel", 3'd2, 1'b1, 1'b0, 1'b0);
        ticks(15);
        check_outs("pu_iso_last", 3'd2, 1'b1, 1'b0, 1'b0);
        ticks(1);
        check_outs("pu_io_on", 3'd3, 1'b1, 1'b1, 1'b0);
        ticks(1);
        check_outs("pu_on", 3'd4, 1'b1, 1'b1, 1'b1);
        ticks(5);
        check_outs("pu_on_hold", 3'd4, 1'b1, 1'b1, 1'b1);

        // Brown-out from ON: ok_s drops after 2 edges, OFF on the next
        DVDD_OK = 1'b0;
        ticks(2);
        check_outs("bo_on_pre", 3'd4, 1'b1, 1'b1, 1'b1);
        ticks(1);
        check_outs("bo_on", 3'd0, 1'b0, 1'b0, 1'b0);

        // One-cycle VDD glitch while the debounce count is 40
        DVDD_OK = 1'b1;
        ticks(3);
        check_outs("gl_deb", 3'd1, 1'b0, 1'b0, 1'b0);
        ticks(38);
        VDD_OK = 1'b0;
        ticks(1);
        VDD_OK = 1'b1;
        ticks(1);
        check_outs("gl_cnt40", 3'd1, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check_outs("gl_off", 3'd0, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check_outs("gl_restart", 3'd1, 1'b0, 1'b0, 1'b0);
        ticks(63);
        check_outs("gl_deb_last", 3'd1, 1'b0, 1'b0, 1'b0);
        ticks(1);
        check_outs("gl_iso_rel", 3'd2, 1'b1, 1'b0, 1'b0);

        // Brown-out landing on the ISO_REL terminal count
        ticks(13);
        DVDD_OK = 1'b0;
        ticks(2);
        check_outs("tc_last", 3'd2, 1'b1, 1'b0, 1'b0);
        ticks(1);
        check_outs("tc_bo", 3'd0, 1'b0, 1'b0, 1'b0);
        ticks(3);
        check_outs("tc_after", 3'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while in IO_ON
        DVDD_OK = 1'b1;
        ticks(83);
        check_outs("rst_io_on", 3'd3, 1'b1, 1'b1, 1'b0);
        #2;
        RSTN = 1'b0;
        #1;
        check_outs("rst_async", 3'd0, 1'b0, 1'b0, 1'b0);
        DVDD_OK = 1'b0;
        VDD_OK  = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        ticks(1);

`ifdef DVDD_SEQ_BROWNOUT_CNT_EN
        check("bo_cnt_reset", BO_COUNT, 8'd0);
        VDD_OK = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            DVDD_OK = 1'b1;
            wait_state("bo_loop_on", 3'd4, 200);
            DVDD_OK = 1'b0;
            wait_state("bo_loop_off", 3'd0, 10);
            if (n == 1)   check("bo_cnt_1", BO_COUNT, 8'd1);
            if (n == 255) check("bo_cnt_255", BO_COUNT, 8'd255);
        end
        check("bo_cnt_sat", BO_COUNT, 8'd255);
        BO_CLR = 1'b1;
        ticks(1);
        BO_CLR = 1'b0;
        check("bo_cnt_clr", BO_COUNT, 8'd0);

        DVDD_OK = 1'b1;
        wait_state("bo_one_on", 3'd4, 200);
        DVDD_OK = 1'b0;
        wait_state("bo_one_off", 3'd0, 10);
        check("bo_cnt_one", BO_COUNT, 8'd1);

        DVDD_OK = 1'b1;
        wait_state("bo_deb_in", 3'd1, 10);
        ticks(10);
        DVDD_OK = 1'b0;
        wait_state("bo_deb_off", 3'd0, 10);
        check("bo_cnt_deb", BO_COUNT, 8'd1);

        DVDD_OK = 1'b1;
        wait_state("bo_clr_on", 3'd4, 200);
        DVDD_OK = 1'b0;
        ticks(2);
        check("bo_clr_pre", {5'd0, STATE}, 8'd4);
        BO_CLR = 1'b1;
        ticks(1);
        BO_CLR = 1'b0;
        check("bo_clr_state", {5'd0, STATE}, 8'd0);
        check("bo_clr_coinc", BO_COUNT, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dvdd_supply_sequencer
